digit_serial_subtractor: RTL and testbench
==========================================

// Module: digit_serial_subtractor
// PURPOSE
//  Multi-cycle N-bit subtractor built as a chain of DIGIT-wide subtract stages.
//  Computes diff = a - b - bin and the final borrow-out, DIGIT bits per clock, LSB digit first.
//  Uses a valid/ready handshake on input and output.
//  Datapath arithmetic unit for wide operands where a full-width ripple subtract misses timing.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of DIGIT
//  DIGIT  4   bits processed per RUN cycle; 1 <= DIGIT <= WIDTH
//  (derived) NDIG = WIDTH/DIGIT = number of RUN cycles; CW = $clog2(NDIG+1) counter width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      operands a, b, bin valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  minuend (unsigned)
//  b          in   WIDTH  subtrahend (unsigned)
//  bin        in   1      borrow-in, for chaining blocks
//  out_valid  out  1      diff/borrow valid
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  borrow     out  1      1 when a < b + bin (unsigned)
//  ovf        out  1      signed overflow; present only with SUB_OVF_FLAG_EN
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE; in_ready=0; out_valid=0; diff=0; borrow=0; ovf=0; counter=0.
//    in_ready rises on the first edge after rst_n is released.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//    - in_ready=1.
//    - On in_valid&&in_ready: latch a, b into shift registers; borrow register <= bin; cnt <= 0; go to RUN.
//  RUN (in_ready=0, out_valid=0), each cycle:
//    - {bd, d} = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - borrow_reg (DIGIT+1 bits).
//    - d is shifted into the MSB end of the result register, which shifts right by DIGIT.
//    - a_sh and b_sh shift right by DIGIT; borrow_reg <= bd; cnt <= cnt+1.
//    - When cnt == NDIG-1: go to DONE.
//  DONE:
//    - out_valid=1.
//    - diff = result register; borrow = borrow_reg.
//    - Outputs are held stable while out_valid && !out_ready.
//    - On out_ready: go to IDLE; out_valid=0 on the next cycle.
//  Latency: operands accepted at edge E; out_valid=1 from edge E+NDIG.
//    Minimum initiation interval is NDIG+2 cycles.
//  in_valid while in_ready=0 is ignored; the upstream holds its data.
//  out_ready while out_valid=0 is ignored.
//  diff/borrow keep their last value in IDLE and RUN. Only out_valid qualifies them.
//  Borrow chaining: the borrow output of the low block feeds bin of the high block.
//  Reset mid-RUN or mid-DONE: the operation is aborted and all outputs return to reset values.
//    No partial result is ever presented.
//  Extremes:
//    - a=0, b=2^WIDTH-1, bin=1 -> diff=0, borrow=1.
//    - DIGIT=WIDTH -> NDIG=1, single RUN cycle.
// CONFIGURATION
//  SUB_OVF_FLAG_EN defined:
//    - ovf port exists.
//    - In DONE: ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the latched operand MSBs.
//    - ovf is reset to 0 and held with diff.
//  SUB_OVF_FLAG_EN undefined: no ovf port and no sign-tracking registers. All other behaviour is identical.
// TESTING (WIDTH=16, DIGIT=4 unless stated)
//  1 a=16'h1234, b=16'h0234, bin=0 -> after 4 RUN cycles: out_valid=1, diff=16'h1000, borrow=0.
//  2 a=16'h0000, b=16'h0001, bin=0 -> diff=16'hFFFF, borrow=1.
//    Same operands with bin=1 -> diff=16'hFFFE, borrow=1.
//  3 Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> diff/borrow stable, in_ready=0;
//    out_ready=1 -> IDLE next cycle, in_ready=1.
//  4 Reset mid-RUN (rst_n=0 at cnt=2) -> next edge: out_valid=0, diff=0, borrow=0;
//    a new transaction after reset produces a correct result.
//  5 With SUB_OVF_FLAG_EN: a=16'h8000, b=16'h0001 -> diff=16'h7FFF, borrow=0, ovf=1;
//    a=16'h0005, b=16'h0003 -> ovf=0.
//  6 DIGIT=1 and DIGIT=16 builds: random operands with random valid/ready gaps -> matches a-b-bin;
//    latency is 16 and 1 cycles respectively.

Source files
------------

// File: rtl/digit_serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per cycle, LSB digit first, valid/ready on both sides.
// Optional signed-overflow flag (ovf port) enabled by defining SUB_OVF_FLAG_EN.
module digit_serial_subtractor #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
`ifdef SUB_OVF_FLAG_EN
   output logic             borrow,
   output logic             ovf
`else
   output logic             borrow
`endif
);

   // state | meaning
   // IDLE  | in_ready high, waiting for operands
   // RUN   | one digit subtracted per cycle, NDIG cycles
   // DONE  | result presented, held until out_ready
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = $clog2(NDIG + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             borrow_reg;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   step;
   logic [WIDTH-1:0] res_next;
`ifdef SUB_OVF_FLAG_EN
   logic             a_msb;
   logic             b_msb;
`endif

   // Result register fills from the MSB end so after NDIG digits the LSB digit sits at bit 0.
   always_comb begin
      step     = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_reg};
      res_next = (res_sh >> DIGIT) | (WIDTH'(step[DIGIT-1:0]) << (WIDTH - DIGIT));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         diff       <= '0;
         borrow     <= 1'b0;
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         borrow_reg <= 1'b0;
         cnt        <= '0;
`ifdef SUB_OVF_FLAG_EN
         ovf        <= 1'b0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  a_sh       <= a;
                  b_sh       <= b;
                  borrow_reg <= bin;
                  cnt        <= '0;
                  in_ready   <= 1'b0;
                  state      <= RUN;
`ifdef SUB_OVF_FLAG_EN
                  a_msb      <= a[WIDTH-1];
                  b_msb      <= b[WIDTH-1];
`endif
               end
            end
            RUN: begin
               a_sh       <= a_sh >> DIGIT;
               b_sh       <= b_sh >> DIGIT;
               res_sh     <= res_next;
               borrow_reg <= step[DIGIT];
               cnt        <= cnt + 1'b1;
               if (cnt == LAST_CNT) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  diff      <= res_next;
                  borrow    <= step[DIGIT];
`ifdef SUB_OVF_FLAG_EN
                  ovf       <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Self-checking bench for digit_serial_subtractor against an arithmetic reference model.
// Covers ovf checks as well when SUB_OVF_FLAG_EN is defined.
module tb_digit_serial_subtractor;
   localparam int W    = 16;
   localparam int D    = 4;
   localparam int NDIG = W / D;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         borrow;
`ifdef SUB_OVF_FLAG_EN
   logic         ovf;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   digit_serial_subtractor #(.WIDTH(W), .DIGIT(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
`ifdef SUB_OVF_FLAG_EN
      .borrow    (borrow),
      .ovf       (ovf)
`else
      .borrow    (borrow)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      longint unsigned m;
      m = (longint'(x) + (longint'(1) << W) * 2 - longint'(y) - longint'(c)) % (longint'(1) << W);
      return m[W-1:0];
   endfunction

   function automatic logic model_borrow(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return longint'(x) < (longint'(y) + longint'(c));
   endfunction

   // Drives one operation; with rnd set, adds idle gaps and ignored in_valid/out_ready noise while busy.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin, input bit rnd,
                         output logic [W-1:0] od, output logic ob, output int lat, output int acc_cyc);
      int n;
      n = 0;
      if (rnd) repeat ($urandom_range(0, 3)) tick();
      while (!in_ready && n < 100) begin tick(); n++; end
      a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
      acc_cyc = cyc + 1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         if (rnd) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
            bin       = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
         end
         tick();
         lat++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      od = diff;
      ob = borrow;
      if (rnd) repeat ($urandom_range(0, 2)) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%h borrow=%b, want 0 0 0000 0",
                  in_ready, out_valid, diff, borrow);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [4] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000};
      logic [W-1:0] vb [4] = '{16'h0234, 16'h0001, 16'h0001, 16'hFFFF};
      logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [W-1:0] ed [4] = '{16'h1000, 16'hFFFF, 16'hFFFE, 16'h0000};
      logic         eb [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic [W-1:0] od;
      logic         ob;
      int           lat, acc;
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], vc[i], 1'b0, od, ob, lat, acc);
         checks++;
         if (od !== ed[i] || ob !== eb[i] || lat != NDIG) begin
            failures++;
            $display("FAIL directed_%0d: diff=%h borrow=%b lat=%0d, want %h %b %0d",
                     i, od, ob, lat, ed[i], eb[i], NDIG);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic [W-1:0] ed;
      ed = model_diff(16'hA5C3, 16'h3C7E, 1'b1);
      while (!in_ready) tick();
      a = 16'hA5C3; b = 16'h3C7E; bin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin tick(); n++; end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== ed || borrow !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_hold_%0d: out_valid=%b in_ready=%b diff=%h borrow=%b, want 1 0 %h 0",
                     i, out_valid, in_ready, diff, borrow, ed);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== ed) begin
         failures++;
         $display("FAIL backpressure_release: out_valid=%b in_ready=%b diff=%h, want 0 1 %h",
                  out_valid, in_ready, diff, ed);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] od;
      logic         ob;
      int           lat, acc;
      while (!in_ready) tick();
      a = 16'h4321; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || diff !== '0 || borrow !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_run: out_valid=%b diff=%h borrow=%b in_ready=%b, want 0 0000 0 0",
                  out_valid, diff, borrow, in_ready);
      end
      rst_n = 1'b1;
      repeat (NDIG + 1) tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_partial: out_valid=%b want 0", out_valid);
      end
      run_op(16'h8001, 16'h0002, 1'b0, 1'b0, od, ob, lat, acc);
      checks++;
      if (od !== 16'h7FFF || ob !== 1'b0) begin
         failures++;
         $display("FAIL after_reset_txn: diff=%h borrow=%b want 7fff 0", od, ob);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] ta, tbv, od;
      logic         tc, ob;
      int           lat, acc;
      for (int i = 0; i < 40; i++) begin
         ta = W'($urandom); tbv = W'($urandom); tc = 1'($urandom_range(0, 1));
         if (i % 8 == 0) ta = tbv;
         run_op(ta, tbv, tc, 1'b1, od, ob, lat, acc);
         checks++;
         if (od !== model_diff(ta, tbv, tc) || ob !== model_borrow(ta, tbv, tc) || lat != NDIG) begin
            failures++;
            $display("FAIL random_%0d a=%h b=%h bin=%b: diff=%h borrow=%b lat=%0d, want %h %b %0d",
                     i, ta, tbv, tc, od, ob, lat, model_diff(ta, tbv, tc), model_borrow(ta, tbv, tc), NDIG);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] od;
      logic         ob;
      int           lat, acc0, acc1;
      run_op(16'h0F0F, 16'h00FF, 1'b0, 1'b0, od, ob, lat, acc0);
      run_op(16'h0001, 16'h0002, 1'b1, 1'b0, od, ob, lat, acc1);
      checks++;
      if (acc1 - acc0 != NDIG + 2 || od !== 16'hFFFE || ob !== 1'b1) begin
         failures++;
         $display("FAIL back_to_back: interval=%0d diff=%h borrow=%b, want %0d fffe 1",
                  acc1 - acc0, od, ob, NDIG + 2);
      end
   endtask

`ifdef SUB_OVF_FLAG_EN
   task automatic test_ovf();
      logic [W-1:0] od;
      logic         ob;
      int           lat, acc;
      logic [W-1:0] ta, tbv;
      logic         eo;
      run_op(16'h8000, 16'h0001, 1'b0, 1'b0, od, ob, lat, acc);
      checks++;
      if (od !== 16'h7FFF || ob !== 1'b0 || ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set: diff=%h borrow=%b ovf=%b want 7fff 0 1", od, ob, ovf);
      end
      run_op(16'h0005, 16'h0003, 1'b0, 1'b0, od, ob, lat, acc);
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear: ovf=%b want 0", ovf);
      end
      for (int i = 0; i < 10; i++) begin
         ta = W'($urandom); tbv = W'($urandom);
         run_op(ta, tbv, 1'b0, 1'b0, od, ob, lat, acc);
         eo = ($signed(ta) - $signed(tbv) > 32767) || ($signed(ta) - $signed(tbv) < -32768);
         checks++;
         if (ovf !== eo) begin
            failures++;
            $display("FAIL ovf_random_%0d a=%h b=%h: ovf=%b want %b", i, ta, tbv, ovf, eo);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      test_back_to_back();
`ifdef SUB_OVF_FLAG_EN
      test_ovf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
